// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction memory loader: FSM state
// encoding, stream framing sizes and the checksum width.
package instr_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_HI,
        ST_HDR_LO,
        ST_BYTE,
        ST_WRITE,
        ST_CHECK,
        ST_DONE
    } state_e;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int CHECKSUM_WIDTH = 8;

    // States in which the loader pulls bytes from the stream.
    function automatic logic accepts_byte(input state_e s);
        return (s == ST_HDR_HI) || (s == ST_HDR_LO) || (s == ST_BYTE) || (s == ST_CHECK);
    endfunction

    // Idle-like states are the only ones that honour start.
    function automatic logic is_quiescent(input state_e s);
        return (s == ST_IDLE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// Packs a big-endian byte stream into 32-bit words: the first byte of each
// word lands in [31:24]; o_word_ready flags the byte that completes a word.
module word_assembler
    import instr_loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_clear,
    input  logic                          i_valid,
    input  logic [7:0]                    i_byte,
    output logic [8*BYTES_PER_WORD-1:0]   o_word,
    output logic                          o_word_ready
);

    localparam int CNT_W  = $clog2(BYTES_PER_WORD);
    localparam int WORD_W = 8 * BYTES_PER_WORD;

    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0] r_word;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else begin
            if (i_clear) begin
                r_cnt <= '0;
            end else if (i_valid) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (i_valid) begin
                r_word <= {r_word[WORD_W-9:0], i_byte};
            end
        end
    end

    assign o_word       = r_word;
    assign o_word_ready = i_valid && (r_cnt == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a length-prefixed program into instruction memory while holding the
// CPU in reset. Define INSTR_LOADER_CHECKSUM_EN to require a trailing checksum.
module instr_mem_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int          HDR_W    = 8 * HDR_BYTES;
    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;
`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam state_e      ST_END   = ST_CHECK;
`else
    localparam state_e      ST_END   = ST_DONE;
`endif

    state_e                  r_state;
    state_e                  w_next;
    logic [HDR_W-9:0]        r_hdr_hi;
    logic [HDR_W-1:0]        r_n;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic [ADDR_WIDTH:0]     r_words;
    logic                    r_error;

    logic                    w_xfer;
    logic                    w_start_ok;
    logic [HDR_W-1:0]        w_hdr_n;
    logic                    w_hdr_zero;
    logic                    w_hdr_bad;
    logic                    w_last_word;
    logic                    w_word_ready;
    logic [31:0]             w_word;
    logic                    w_cksum_bad;

    assign w_xfer      = byte_valid && byte_ready;
    assign w_start_ok  = start && is_quiescent(r_state);
    assign w_hdr_n     = {r_hdr_hi, byte_in};
    assign w_hdr_zero  = (w_hdr_n == '0);
    assign w_hdr_bad   = 32'(w_hdr_n) > CAPACITY;
    assign w_last_word = (32'(r_words) + 32'd1) >= 32'(r_n);

    word_assembler u_word_assembler (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_start_ok),
        .i_valid      (w_xfer && (r_state == ST_BYTE)),
        .i_byte       (byte_in),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [CHECKSUM_WIDTH-1:0] r_sum;

    // Running sum covers payload bytes only; header and checksum are excluded.
    always_ff @(posedge clk) begin
        if (reset || w_start_ok) begin
            r_sum <= '0;
        end else if (w_xfer && (r_state == ST_BYTE)) begin
            r_sum <= r_sum + byte_in;
        end
    end

    assign w_cksum_bad = (byte_in != r_sum);
`else
    assign w_cksum_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every always_comb output gets its default before the case so no
    // path through it leaves a value unassigned and infers a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) w_next = ST_HDR_HI;
            end
            ST_HDR_HI: begin
                if (w_xfer) w_next = ST_HDR_LO;
            end
            ST_HDR_LO: begin
                if (w_xfer) begin
                    if (w_hdr_zero)     w_next = ST_END;
                    else if (w_hdr_bad) w_next = ST_DONE;
                    else                w_next = ST_BYTE;
                end
            end
            ST_BYTE: begin
                if (w_word_ready) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                w_next = w_last_word ? ST_END : ST_BYTE;
            end
            ST_CHECK: begin
                if (w_xfer) w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hdr_hi <= '0;
            r_n      <= '0;
            r_idx    <= '0;
            r_words  <= '0;
            r_error  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_idx   <= '0;
                        r_words <= '0;
                        r_error <= 1'b0;
                    end
                end
                ST_HDR_HI: begin
                    if (w_xfer) r_hdr_hi <= byte_in;
                end
                ST_HDR_LO: begin
                    if (w_xfer) begin
                        r_n     <= w_hdr_n;
                        r_error <= w_hdr_bad;
                    end
                end
                ST_WRITE: begin
                    // idx stops at N-1 so the address never wraps at full capacity.
                    r_words <= r_words + (ADDR_WIDTH + 1)'(1);
                    if (!w_last_word) r_idx <= r_idx + ADDR_WIDTH'(1);
                end
                ST_CHECK: begin
                    if (w_xfer) r_error <= w_cksum_bad;
                end
                default: ;
            endcase
        end
    end

    assign byte_ready   = accepts_byte(r_state);
    assign cpu_hold     = !is_quiescent(r_state);
    assign done         = (r_state == ST_DONE);
    assign mem_we       = (r_state == ST_WRITE);
    assign mem_addr     = 32'({r_idx, 2'b00});
    assign mem_wdata    = w_word;
    assign error        = r_error;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader; checksum cases run when the design is
// built with INSTR_LOADER_CHECKSUM_EN.
module tb_instr_mem_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int word_first_cyc = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    instr_mem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory-side log of every write, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_byte_ready"},   32'(byte_ready),   0);
        check({pfx, "_mem_we"},       32'(mem_we),       0);
        check({pfx, "_mem_addr"},     mem_addr,          0);
        check({pfx, "_mem_wdata"},    mem_wdata,         0);
        check({pfx, "_cpu_hold"},     32'(cpu_hold),     0);
        check({pfx, "_done"},         32'(done),         0);
        check({pfx, "_error"},        32'(error),        0);
        check({pfx, "_words_loaded"}, 32'(words_loaded), 0);
    endtask

    // Presents one byte (after an optional idle gap) and returns in the cycle
    // after it transfers; valid stays high so a continuous stream has no bubbles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget;
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) tick();
        end
        byte_valid = 1'b1;
        byte_in    = b;
        budget     = 0;
        while (!byte_ready && budget < 20) begin
            tick();
            budget++;
        end
        if (!byte_ready) check("byte_ready_wait", 32'(byte_ready), 1);
        word_first_cyc = cyc;
        tick();
    endtask

    // Sends a word MSB first and checks the single WRITE cycle that follows.
    task automatic send_word(input logic [31:0] w, input int idx, input int gap_max);
        int first;
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31-8*i -: 8], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
            if (i == 0) first = word_first_cyc;
        end
        word_first_cyc = first;
        check($sformatf("we_w%0d", idx),    32'(mem_we),     1);
        check($sformatf("ready_w%0d", idx), 32'(byte_ready), 0);
        check($sformatf("addr_w%0d", idx),  mem_addr,        32'(idx) << 2);
        check($sformatf("data_w%0d", idx),  mem_wdata,       w);
    endtask

    task automatic load_header(input logic [15:0] n, input int gap);
        start = 1'b1;
        tick();
        start = 1'b0;
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
    endtask

    // Ends the stream: checksum byte when enabled, otherwise one cycle past
    // the last WRITE. Either way the bench sits in the first DONE cycle.
    task automatic finish_load(input logic [7:0] cks);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(cks, 0);
        byte_valid = 1'b0;
`else
        byte_valid = 1'b0;
        if (cks == 8'hFF) byte_in = 8'h00;
        tick();
`endif
    endtask

    function automatic logic [7:0] word_sum(input logic [31:0] w);
        return w[31:24] + w[23:16] + w[15:8] + w[7:0];
    endfunction

    initial begin
        int first;
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        repeat (2) tick();
        check_idle_outputs("rst");
        reset = 1'b0;
        tick();

        // Continuous stream, two words.
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_hold_after_start",  32'(cpu_hold),   1);
        check("t1_ready_after_start", 32'(byte_ready), 1);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(32'h2008_0005, 0, 0);
        first = word_first_cyc;
        send_word(32'h2009_0003, 1, 0);
        // Bytes at c..c+3, write c+4, bytes c+5..c+8, last write c+9: 10 cycles inclusive.
        check("t1_span", 32'(cyc - first), 9);
        finish_load(8'h59);
        check("t1_done",    32'(done),         1);
        check("t1_hold",    32'(cpu_hold),     0);
        check("t1_error",   32'(error),        0);
        check("t1_words",   32'(words_loaded), 2);
        check("t1_ready",   32'(byte_ready),   0);
        check("t1_nwrites", 32'(wr_addr.size()), 2);
        if (wr_addr.size() == 2) begin
            check("t1_log_a0", wr_addr[0], 32'h0);
            check("t1_log_d0", wr_data[0], 32'h2008_0005);
            check("t1_log_a1", wr_addr[1], 32'h4);
            check("t1_log_d1", wr_data[1], 32'h2009_0003);
        end

        // Same program with random idle gaps, restarted from DONE.
        clear_log();
        load_header(16'h0002, 3);
        check("t2_done_cleared", 32'(done), 0);
        send_word(32'h2008_0005, 0, 3);
        send_word(32'h2009_0003, 1, 3);
        finish_load(8'h59);
        check("t2_done",    32'(done),  1);
        check("t2_error",   32'(error), 0);
        check("t2_nwrites", 32'(wr_addr.size()), 2);
        if (wr_data.size() == 2) begin
            check("t2_log_d0", wr_data[0], 32'h2008_0005);
            check("t2_log_d1", wr_data[1], 32'h2009_0003);
        end

        // Empty program.
        clear_log();
        load_header(16'h0000, 0);
`ifdef INSTR_LOADER_CHECKSUM_EN
        check("t3_wait_cks", 32'(byte_ready), 1);
        send_byte(8'h00, 0);
`endif
        byte_valid = 1'b0;
        check("t3_done",    32'(done),         1);
        check("t3_error",   32'(error),        0);
        check("t3_words",   32'(words_loaded), 0);
        check("t3_nwrites", 32'(wr_addr.size()), 0);

        // Oversized program: 257 words into a 256-word memory.
        clear_log();
        load_header(16'h0101, 0);
        byte_valid = 1'b0;
        check("t4_done",  32'(done),       1);
        check("t4_error", 32'(error),      1);
        check("t4_ready", 32'(byte_ready), 0);
        tick();
        check("t4_nwrites", 32'(wr_addr.size()), 0);

        // Reset mid-load, with a start pulse ignored while busy.
        clear_log();
        load_header(16'h000C, 0);
        send_word(32'h1000_0000, 0, 0);
        byte_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_start_ignored_hold",  32'(cpu_hold),     1);
        check("t5_start_ignored_words", 32'(words_loaded), 1);
        send_word(32'h1000_0001, 1, 0);
        send_word(32'h1000_0002, 2, 0);
        byte_valid = 1'b0;
        tick();
        check("t5_words_before_reset", 32'(words_loaded), 3);
        reset = 1'b1;
        tick();
        check_idle_outputs("t5_reset");
        reset = 1'b0;
        check("t5_nwrites", 32'(wr_addr.size()), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < wr_addr.size()) check($sformatf("t5_log_a%0d", i), wr_addr[i], 32'(i) << 2);
        end
        clear_log();
        load_header(16'h0001, 0);
        send_word(32'hDEAD_BEEF, 0, 0);
        finish_load(word_sum(32'hDEAD_BEEF));
        check("t5_reload_done",  32'(done),         1);
        check("t5_reload_words", 32'(words_loaded), 1);
        check("t5_reload_err",   32'(error),        0);
        if (wr_addr.size() == 1) check("t5_reload_addr", wr_addr[0], 32'h0);

`ifdef INSTR_LOADER_CHECKSUM_EN
        // 01+02+03+04 = 0x0A.
        load_header(16'h0001, 0);
        send_word(32'h0102_0304, 0, 0);
        finish_load(8'h0A);
        check("t6_good_done",  32'(done),  1);
        check("t6_good_error", 32'(error), 0);
        clear_log();
        load_header(16'h0001, 0);
        send_word(32'h0102_0304, 0, 0);
        finish_load(8'h0B);
        check("t6_bad_done",    32'(done),  1);
        check("t6_bad_error",   32'(error), 1);
        check("t6_bad_nwrites", 32'(wr_addr.size()), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
